// File: rtl/gb80_pkg.sv
// rtl/gb80_pkg.sv - shared GB80 register-file encodings and pair indices
package gb80_pkg;

    localparam logic [1:0] PAIR_OP_NONE = 2'b00;
    localparam logic [1:0] PAIR_OP_INC  = 2'b01;
    localparam logic [1:0] PAIR_OP_DEC  = 2'b10;
    localparam logic [1:0] PAIR_OP_RSVD = 2'b11;

    // Pair indices for the NUM_REGS=8 build; even register of each pair is the high byte
    localparam int PAIR_BC = 0;
    localparam int PAIR_DE = 1;
    localparam int PAIR_HL = 2;
    localparam int PAIR_AF = 3;

endpackage

// File: rtl/pair_incdec.sv
// rtl/pair_incdec.sv - combinational modulo increment/decrement of a register pair
module pair_incdec
    import gb80_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             wrap
);

    always_comb begin
        result = value;
        wrap   = 1'b0;
        case (op)
            PAIR_OP_INC: {wrap, result} = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
            PAIR_OP_DEC: begin
                result = value - {{(WIDTH-1){1'b0}}, 1'b1};
                wrap   = (value == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - GB80 byte/pair register file; REGFILE_BYPASS_EN forwards same-cycle writes to reads
module register_file
    import gb80_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_we,
    input  logic [ADDR_WIDTH-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic                      i_pair_we,
    input  logic [ADDR_WIDTH-2:0]     i_pair_wsel,
    input  logic [2*DATA_WIDTH-1:0]   i_pair_wdata,
    input  logic [1:0]                i_pair_op,
    input  logic [ADDR_WIDTH-2:0]     i_pair_osel,
    input  logic [ADDR_WIDTH-1:0]     i_raddr_a,
    input  logic [ADDR_WIDTH-1:0]     i_raddr_b,
    input  logic [ADDR_WIDTH-2:0]     i_pair_rsel,
    output logic [DATA_WIDTH-1:0]     o_rdata_a,
    output logic [DATA_WIDTH-1:0]     o_rdata_b,
    output logic [2*DATA_WIDTH-1:0]   o_pair_rdata,
    output logic                      o_wrap
);

    logic [DATA_WIDTH-1:0]   regs      [NUM_REGS];
    logic [DATA_WIDTH-1:0]   next_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   view      [NUM_REGS];
    logic [2*DATA_WIDTH-1:0] op_value;
    logic [2*DATA_WIDTH-1:0] op_result;
    logic                    op_wrap;

    assign op_value = {regs[{i_pair_osel, 1'b0}], regs[{i_pair_osel, 1'b1}]};

    pair_incdec #(
        .WIDTH (2*DATA_WIDTH)
    ) u_pair_incdec (
        .value  (op_value),
        .op     (i_pair_op),
        .result (op_result),
        .wrap   (op_wrap)
    );

    // Later assignments win: op result, then pair write, then byte write
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            next_regs[i] = regs[i];
        end
        next_regs[{i_pair_osel, 1'b0}] = op_result[2*DATA_WIDTH-1:DATA_WIDTH];
        next_regs[{i_pair_osel, 1'b1}] = op_result[DATA_WIDTH-1:0];
        if (i_pair_we) begin
            next_regs[{i_pair_wsel, 1'b0}] = i_pair_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
            next_regs[{i_pair_wsel, 1'b1}] = i_pair_wdata[DATA_WIDTH-1:0];
        end
        if (i_we) begin
            next_regs[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            o_wrap <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= next_regs[i];
            end
            o_wrap <= op_wrap;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_BYPASS_EN
            view[i] = next_regs[i];
`else
            view[i] = regs[i];
`endif
        end
    end

    assign o_rdata_a    = view[i_raddr_a];
    assign o_rdata_b    = view[i_raddr_b];
    assign o_pair_rdata = {view[{i_pair_rsel, 1'b0}], view[{i_pair_rsel, 1'b1}]};

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - vector table, corner sequences and random model check of register_file
module tb_register_file;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_we;
    logic [2:0]  i_waddr;
    logic [7:0]  i_wdata;
    logic        i_pair_we;
    logic [1:0]  i_pair_wsel;
    logic [15:0] i_pair_wdata;
    logic [1:0]  i_pair_op;
    logic [1:0]  i_pair_osel;
    logic [2:0]  i_raddr_a;
    logic [2:0]  i_raddr_b;
    logic [1:0]  i_pair_rsel;
    logic [7:0]  o_rdata_a;
    logic [7:0]  o_rdata_b;
    logic [15:0] o_pair_rdata;
    logic        o_wrap;

    int checks = 0;
    int failures = 0;

    register_file dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_we         (i_we),
        .i_waddr      (i_waddr),
        .i_wdata      (i_wdata),
        .i_pair_we    (i_pair_we),
        .i_pair_wsel  (i_pair_wsel),
        .i_pair_wdata (i_pair_wdata),
        .i_pair_op    (i_pair_op),
        .i_pair_osel  (i_pair_osel),
        .i_raddr_a    (i_raddr_a),
        .i_raddr_b    (i_raddr_b),
        .i_pair_rsel  (i_pair_rsel),
        .o_rdata_a    (o_rdata_a),
        .o_rdata_b    (o_rdata_b),
        .o_pair_rdata (o_pair_rdata),
        .o_wrap       (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [7:0]  wdata;
        logic        pair_we;
        logic [1:0]  pair_wsel;
        logic [15:0] pair_wdata;
        logic [1:0]  op;
        logic [1:0]  osel;
        logic [1:0]  rsel;
        logic [15:0] exp_pair;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[$];

    // Reference model: register contents as plain integers
    int m  [8];
    int mn [8];
    int wn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        i_we = 1'b0; i_waddr = '0; i_wdata = '0;
        i_pair_we = 1'b0; i_pair_wsel = '0; i_pair_wdata = '0;
        i_pair_op = 2'b00; i_pair_osel = '0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic dump_check(input string name, input int exp);
        for (int i = 0; i < 8; i++) begin
            i_raddr_a = 3'(i);
            i_raddr_b = 3'(7 - i);
            #1;
            chk({name, "_a"}, {24'h0, o_rdata_a}, 32'(exp));
            chk({name, "_b"}, {24'h0, o_rdata_b}, 32'(exp));
        end
    endtask

    task automatic add_vec(input logic we, input logic [2:0] waddr, input logic [7:0] wdata,
                           input logic pwe, input logic [1:0] wsel, input logic [15:0] pwdata,
                           input logic [1:0] op, input logic [1:0] osel,
                           input logic [1:0] rsel, input logic [15:0] ep, input logic ew);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.pair_we = pwe; v.pair_wsel = wsel; v.pair_wdata = pwdata;
        v.op = op; v.osel = osel; v.rsel = rsel; v.exp_pair = ep; v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic model_next();
        int pv;
        int nv;
        int o;
        for (int i = 0; i < 8; i++) mn[i] = m[i];
        wn = 0;
        o  = int'(i_pair_osel);
        pv = m[2*o] * 256 + m[2*o+1];
        nv = -1;
        if (i_pair_op == 2'b01) begin
            nv = (pv + 1) % 65536;
            wn = (pv == 65535) ? 1 : 0;
        end else if (i_pair_op == 2'b10) begin
            nv = (pv + 65535) % 65536;
            wn = (pv == 0) ? 1 : 0;
        end
        if (nv >= 0) begin
            mn[2*o]   = nv / 256;
            mn[2*o+1] = nv % 256;
        end
        if (i_pair_we) begin
            mn[2*int'(i_pair_wsel)]   = int'(i_pair_wdata) / 256;
            mn[2*int'(i_pair_wsel)+1] = int'(i_pair_wdata) % 256;
        end
        if (i_we) mn[int'(i_waddr)] = int'(i_wdata);
    endtask

    initial begin
        idle();
        i_raddr_a = '0; i_raddr_b = '0; i_pair_rsel = '0;
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        dump_check("reset_state", 0);
        chk("reset_wrap", {31'h0, o_wrap}, 32'h0);

        // Sequential vectors over shared state, starting from all-zero registers
        add_vec(1, 3'd2, 8'h12, 0, 2'd0, 16'h0000, 2'b00, 2'd0, 2'd1, 16'h1200, 0);
        add_vec(0, 3'd0, 8'h00, 1, 2'd1, 16'h3456, 2'b00, 2'd0, 2'd1, 16'h3456, 0);
        add_vec(0, 3'd0, 8'h00, 1, 2'd2, 16'hFFFF, 2'b00, 2'd0, 2'd2, 16'hFFFF, 0);
        add_vec(0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b01, 2'd2, 2'd2, 16'h0000, 1);
        add_vec(0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b00, 2'd0, 2'd2, 16'h0000, 0);
        add_vec(0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b10, 2'd0, 2'd0, 16'hFFFF, 1);
        add_vec(0, 3'd0, 8'h00, 1, 2'd0, 16'h0100, 2'b00, 2'd0, 2'd0, 16'h0100, 0);
        add_vec(0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b10, 2'd0, 2'd0, 16'h00FF, 0);
        add_vec(0, 3'd0, 8'h00, 1, 2'd3, 16'h10FF, 2'b00, 2'd0, 2'd3, 16'h10FF, 0);
        add_vec(1, 3'd7, 8'hAA, 0, 2'd0, 16'h0000, 2'b01, 2'd3, 2'd3, 16'h11AA, 0);
        add_vec(0, 3'd0, 8'h00, 1, 2'd3, 16'h1234, 2'b01, 2'd3, 2'd3, 16'h1234, 0);
        add_vec(0, 3'd0, 8'h00, 1, 2'd2, 16'hFFFF, 2'b00, 2'd0, 2'd2, 16'hFFFF, 0);
        add_vec(0, 3'd0, 8'h00, 1, 2'd2, 16'h5555, 2'b01, 2'd2, 2'd2, 16'h5555, 1);
        add_vec(0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b11, 2'd1, 2'd1, 16'h3456, 0);
        add_vec(1, 3'd4, 8'h99, 1, 2'd1, 16'hBEEF, 2'b01, 2'd0, 2'd0, 16'h0100, 0);
        add_vec(0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b00, 2'd0, 2'd1, 16'hBEEF, 0);
        add_vec(0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b00, 2'd0, 2'd2, 16'h9955, 0);
        add_vec(1, 3'd3, 8'h22, 1, 2'd1, 16'h1111, 2'b00, 2'd0, 2'd1, 16'h1122, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            i_we = vecs[k].we; i_waddr = vecs[k].waddr; i_wdata = vecs[k].wdata;
            i_pair_we = vecs[k].pair_we; i_pair_wsel = vecs[k].pair_wsel;
            i_pair_wdata = vecs[k].pair_wdata;
            i_pair_op = vecs[k].op; i_pair_osel = vecs[k].osel;
            tick();
            idle();
            i_pair_rsel = vecs[k].rsel;
            #1;
            chk($sformatf("vec%0d_pair", k), {16'h0, o_pair_rdata}, {16'h0, vecs[k].exp_pair});
            chk($sformatf("vec%0d_wrap", k), {31'h0, o_wrap}, {31'h0, vecs[k].exp_wrap});
        end

        // Reset between edges with wrap set and a write pending
        for (int p = 0; p < 4; p++) begin
            i_pair_we = 1'b1; i_pair_wsel = 2'(p); i_pair_wdata = 16'hA5A5;
            tick();
        end
        idle();
        dump_check("preload", 8'hA5);
        i_pair_we = 1'b1; i_pair_wsel = 2'd2; i_pair_wdata = 16'hFFFF;
        tick();
        idle();
        i_pair_op = 2'b01; i_pair_osel = 2'd2;
        tick();
        idle();
        chk("prereset_wrap", {31'h0, o_wrap}, 32'h1);
        i_we = 1'b1; i_waddr = 3'd5; i_wdata = 8'h3C;
        #2;
        i_reset = 1'b1;
        #1;
        chk("async_reset_wrap", {31'h0, o_wrap}, 32'h0);
        dump_check("async_reset", 0);
        tick();
        dump_check("held_reset", 0);
        i_reset = 1'b0;
        idle();
        #1;
        dump_check("after_reset", 0);

        // Same-cycle read of a byte being written
        i_reg1_write();

        // Randomized traffic against the model
        i_reset = 1'b1;
        #1;
        i_reset = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = 0;
        for (int n = 0; n < 400; n++) begin
            i_we         = 1'($urandom_range(0, 1));
            i_waddr      = 3'($urandom);
            i_wdata      = 8'($urandom);
            i_pair_we    = ($urandom_range(0, 3) == 0);
            i_pair_wsel  = 2'($urandom);
            case ($urandom_range(0, 3))
                0: i_pair_wdata = 16'hFFFF;
                1: i_pair_wdata = 16'h0000;
                default: i_pair_wdata = 16'($urandom);
            endcase
            i_pair_op    = 2'($urandom);
            i_pair_osel  = 2'($urandom);
            i_raddr_a    = 3'($urandom);
            i_raddr_b    = 3'($urandom);
            i_pair_rsel  = 2'($urandom);
            #1;
            model_next();
`ifdef REGFILE_BYPASS_EN
            chk("rand_rd_a", {24'h0, o_rdata_a}, 32'(mn[int'(i_raddr_a)]));
            chk("rand_rd_b", {24'h0, o_rdata_b}, 32'(mn[int'(i_raddr_b)]));
            chk("rand_pair", {16'h0, o_pair_rdata},
                32'(mn[2*int'(i_pair_rsel)] * 256 + mn[2*int'(i_pair_rsel)+1]));
`else
            chk("rand_rd_a", {24'h0, o_rdata_a}, 32'(m[int'(i_raddr_a)]));
            chk("rand_rd_b", {24'h0, o_rdata_b}, 32'(m[int'(i_raddr_b)]));
            chk("rand_pair", {16'h0, o_pair_rdata},
                32'(m[2*int'(i_pair_rsel)] * 256 + m[2*int'(i_pair_rsel)+1]));
`endif
            tick();
            for (int i = 0; i < 8; i++) m[i] = mn[i];
            chk("rand_wrap", {31'h0, o_wrap}, 32'(wn));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic i_reg1_write();
        i_we = 1'b1; i_waddr = 3'd1; i_wdata = 8'h77;
        i_raddr_a = 3'd1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_before_edge", {24'h0, o_rdata_a}, 32'h77);
`else
        chk("nobypass_before_edge", {24'h0, o_rdata_a}, 32'h00);
`endif
        tick();
        idle();
        #1;
        chk("write_after_edge", {24'h0, o_rdata_a}, 32'h77);
    endtask

endmodule
